// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the pipeline registers.
// Holds the word width, the HLT opcode and the fetch-state encoding.
package fetch_stage_pkg;

  localparam int WORD_W = 16;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  function automatic logic [3:0] opcode(input logic [WORD_W-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

  function automatic logic is_hlt(input logic [WORD_W-1:0] word);
    return opcode(word) == OP_HLT;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register: instruction, pc+2 and a valid bit.
// Flush clears only the valid bit and takes priority over load.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] instr_in,
  input  logic [W-1:0] pc_plus2_in,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc_plus2,
  output logic         valid
);

  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pc_plus2_q, pc_plus2_d;
  logic         valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      instr_d    = instr_in;
      pc_plus2_d = pc_plus2_in;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus2 = pc_plus2_q;
  assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request/ready handshake, skid and
// pending-redirect registers, and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [WORD_W-1:0] br_target,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc_plus2,
  output logic              ifid_valid,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] skid_q, skid_d;
  logic [WORD_W-1:0] pending_q, pending_d;
  logic [WORD_W-1:0] pc_plus2;
  logic [WORD_W-1:0] ifid_din;
  logic              ifid_load;
  logic              ifid_flush;

  assign pc_plus2 = pc_q + 16'd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      skid_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      skid_q    <= skid_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    pending_d  = pending_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_din   = imem_rdata;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (br_taken) begin
            ifid_flush = 1'b1;
            pc_d       = br_target;
          end else if (!stall) begin
            ifid_load = 1'b1;
            if (is_hlt(imem_rdata)) state_d = HALT;
            else                    pc_d    = pc_plus2;
          end else begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (br_taken) begin
          // Request still outstanding: remember the target until it drains.
          pending_d  = br_target;
          ifid_flush = 1'b1;
          state_d    = DRAIN;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end
      HOLD: begin
        ifid_din = skid_q;
        if (br_taken) begin
          ifid_flush = 1'b1;
          pc_d       = br_target;
          state_d    = FETCH;
        end else if (!stall) begin
          ifid_load = 1'b1;
          if (is_hlt(skid_q)) begin
            state_d = HALT;
          end else begin
            pc_d    = pc_plus2;
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        ifid_flush = 1'b1;
        if (br_taken) pending_d = br_target;
        if (imem_ready) begin
          // A redirect landing on the drain cycle is newer than pending.
          pc_d    = br_taken ? br_target : pending_q;
          state_d = FETCH;
        end
      end
      HALT: begin
        if (br_taken) begin
          ifid_flush = 1'b1;
          pc_d       = br_target;
          state_d    = FETCH;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Memory-side outputs depend on state and pc only.
  always_comb begin
    imem_req  = 1'b0;
    halted    = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      FETCH, DRAIN: imem_req = 1'b1;
      HALT:         halted   = 1'b1;
      default:      ;
    endcase
  end

  ifid_reg #(
    .W(WORD_W)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .instr_in   (ifid_din),
    .pc_plus2_in(pc_plus2),
    .instr      (ifid_instr),
    .pc_plus2   (ifid_pc_plus2),
    .valid      (ifid_valid)
  );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the 16-bit pipelined core. Holds the PC, drives a variable-latency instruction-memory request/ready interface, and loads the IF/ID pipeline register. The decode-stage opcode decoder consumes its `ifid_instr[15:12]`. It absorbs hazard stalls, branch redirects and halt (`opcode 4'hF`) so that decode only ever sees a valid, correctly ordered instruction stream.

## Interface
- `RESET_PC`, default `16'h0000`: PC value after reset.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `stall  in  1`: hold IF/ID contents (hazard unit).
- `br_taken  in  1`: one-cycle redirect pulse from the branch-resolve stage.
- `br_target  in  16`: redirect PC; valid when `br_taken`=1.
- `imem_req  out  1`: fetch request.
- `imem_addr  out  16`: fetch address; stable while `imem_req & ~imem_ready`.
- `imem_ready  in  1`: data valid this cycle; may be asserted in the same cycle as `imem_req`.
- `imem_rdata  in  16`: instruction word.
- `ifid_instr  out  16`: IF/ID instruction.
- `ifid_pc_plus2  out  16`: IF/ID fetch PC + 2, used for PCS and branch targets.
- `ifid_valid  out  1`: IF/ID holds a real instruction; 0 means bubble.
- `halted  out  1`: the fetch unit has stopped on HLT.

## Operation
- States:
  - FETCH: `imem_req`=1, `imem_addr`=pc.
  - HOLD: a fetched word is parked in the skid register because of `stall`; `imem_req`=0.
  - DRAIN: a redirect arrived during an outstanding request; `imem_req`=1, `imem_addr`=old pc.
  - HALT: `imem_req`=0, `halted`=1.
- FETCH with `imem_ready`:
  - If `br_taken`: discard the word, pc<=`br_target`, `ifid_valid`<=0, stay in FETCH.
  - Else if `~stall`: IF/ID<={rdata, pc+2, 1}. If rdata[15:12]==4'hF, go to HALT with pc unchanged. Otherwise pc<=pc+2.
  - Else (`stall`): skid<=rdata, go to HOLD. IF/ID and pc are unchanged.
- FETCH without `imem_ready`:
  - If `br_taken`: save `br_target` in the pending register, `ifid_valid`<=0, go to DRAIN.
  - Else if `~stall`: `ifid_valid`<=0 (bubble).
  - Else (`stall`): IF/ID holds.
- HOLD:
  - If `br_taken`: drop the skid word, pc<=`br_target`, `ifid_valid`<=0, go to FETCH.
  - Else if `~stall`: IF/ID<={skid, pc+2, 1}. Advance pc, or go to HALT, using the same rules as FETCH. Otherwise go to FETCH.
- DRAIN:
  - On `imem_ready`: discard the data, pc<=pending, go to FETCH.
  - A further `br_taken` overwrites pending. The latest redirect wins.
  - `ifid_valid` stays 0.
- HALT:
  - While `~stall`, `ifid_valid`<=0 after the HLT word has advanced.
  - On `br_taken`: the HLT was wrong-path. pc<=`br_target`, `halted`<=0, `ifid_valid`<=0, go to FETCH.
  - Otherwise HALT is held until `rst`.
- Priority: `br_taken` flush > `stall` hold > normal advance.
- PC arithmetic: 16-bit, +2, wraps from 16'hFFFE to 16'h0000 with no flag.

## Timing
- Reset values:
  - state FETCH, pc=`RESET_PC`.
  - `imem_req`=1, `imem_addr`=`RESET_PC`.
  - `ifid_instr`=16'h0000, `ifid_pc_plus2`=16'h0000, `ifid_valid`=0.
  - `halted`=0, skid=0, pending=0.
- Latency: a word returned with `imem_ready` in cycle N appears on IF/ID in cycle N+1.
- Throughput: one instruction per cycle when `imem_ready` is held high and `stall`=0.
- Redirect: `br_target` is presented on `imem_addr` in cycle N+1 after `br_taken` in cycle N (FETCH/HOLD case), or in the cycle after `imem_ready` (DRAIN case).
- `imem_req`, `imem_addr` and `halted` are decoded combinationally from state and pc only, never from `imem_ready` or `stall`.
- Reset mid-transaction: state returns to FETCH immediately. The in-flight memory response is not tracked.

## Structure
- Shared package:
  - `OP_HLT` = 4'hF.
  - Opcode field slice [15:12].
  - Fetch-state enum {FETCH, HOLD, DRAIN, HALT}.
  - Word width, 16.
- Sub-module `ifid_reg`: the IF/ID pipeline register, with load-enable, flush (clears valid) and async reset. It is reused by the later pipeline registers.
- The PC, skid, pending and FSM logic live in `fetch_stage`.

## Test plan
- Reset, then `imem_ready`=1 constantly with words 16'h1234, 16'h5678: `imem_addr` runs 0, 2, 4; IF/ID shows {16'h1234, 16'h0002, 1}, then {16'h5678, 16'h0004, 1}.
- Memory latency 3 with `stall` asserted when the data returns: the FSM enters HOLD with `imem_req`=0. On release, IF/ID is loaded with the skid word and pc advances by exactly 2, with no duplicate and no lost instruction.
- `br_taken` with `br_target`=16'h0040 while a 3-cycle request to 16'h0006 is outstanding: the FSM goes through DRAIN, the response is discarded, the next `imem_addr` is 16'h0040, and `ifid_valid` stays 0 throughout.
- Fetch of 16'hF000 at pc 16'h000A: `halted`=1, `imem_req`=0, pc stays 16'h000A, and IF/ID shows the HLT word for one cycle and then a bubble.
- While halted, pulse `br_taken` with `br_target`=16'h0020: `halted`=0, and fetch resumes at 16'h0020.
- `br_taken` and `stall` in the same cycle with `imem_ready`=1: `ifid_valid`<=0 and pc<=`br_target` (flush wins over stall).
